// File: rtl/tone_sequencer.sv
// Multi-channel square-wave tone sequencer. Steps through a song held in an
// external synchronous ROM. Each step gives per-channel half-periods and a
// duration in ticks. Outputs are active-low buzzers that idle high.

// One tone channel: holds its half-period, counts 0..hp-1 and flips phase on wrap.
module tone_ch #(
    parameter int HP_W = 20
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ld,
    input  logic            en,
    input  logic [HP_W-1:0] hp_in,
    output logic            bz
);
    logic [HP_W-1:0] hp_q, hp_d;
    logic [HP_W-1:0] cnt_q, cnt_d;
    logic            ph_q, ph_d;

    // Capture half-period on load; advance the counter only while playing unpaused.
    always_comb begin
        hp_d  = hp_q;
        cnt_d = cnt_q;
        ph_d  = ph_q;
        if (ld) begin
            hp_d  = hp_in;
            cnt_d = '0;
            ph_d  = 1'b0;
        end else if (en && hp_q != '0) begin
            if (cnt_q == hp_q - 1'b1) begin
                cnt_d = '0;
                ph_d  = ~ph_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hp_q  <= '0;
            cnt_q <= '0;
            ph_q  <= 1'b0;
        end else begin
            hp_q  <= hp_d;
            cnt_q <= cnt_d;
            ph_q  <= ph_d;
        end
    end

    // Phase 0 is the first (low) half; a rest (hp=0) stays high.
    assign bz = ~(en && (hp_q != '0) && !ph_q);
endmodule

module tone_sequencer #(
    parameter int CH       = 2,
    parameter int AW       = 9,
    parameter int HP_W     = 20,
    parameter int DUR_W    = 8,
    parameter int TICK_CYC = 6_250_000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     pause,
    input  logic                     loop_en,
    input  logic [AW-1:0]            len,
    output logic [AW-1:0]            rom_addr,
    input  logic [CH*HP_W+DUR_W-1:0] rom_data,
    output logic                     busy,
    output logic                     done,
    output logic [CH-1:0]            buzzer
);
    localparam int TW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYC - 1);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_PLAY, S_END} state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [AW-1:0]    len_q, len_d;
    logic [DUR_W-1:0] dur_q, dur_d;
    logic [DUR_W-1:0] dcnt_q, dcnt_d;
    logic [TW-1:0]    tick_q, tick_d;
    logic             adv;
    logic             run;
    logic             ld;

    assign run = (state_q == S_PLAY) && !pause;
    assign ld  = (state_q == S_LOAD);

    // Sequencing: fetch/load each step, time the note in ticks, then advance.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        dur_d   = dur_q;
        dcnt_d  = dcnt_q;
        tick_d  = tick_q;
        adv     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    len_d   = len;
                    addr_d  = '0;
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                dur_d  = rom_data[DUR_W-1:0];
                dcnt_d = '0;
                tick_d = '0;
                if (rom_data[DUR_W-1:0] == '0) adv = 1'b1;
                else                            state_d = S_PLAY;
            end
            S_PLAY: begin
                if (!pause) begin
                    if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        if (dcnt_q == dur_q - 1'b1) adv = 1'b1;
                        else                        dcnt_d = dcnt_q + 1'b1;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            S_END: begin
                state_d = S_IDLE;
                addr_d  = '0;
            end
            default: begin
                state_d = S_IDLE;
                addr_d  = '0;
            end
        endcase
        // Step advance: next step, wrap when looping, or finish.
        if (adv) begin
            if (addr_q != len_q) begin
                addr_d  = addr_q + 1'b1;
                state_d = S_FETCH;
            end else if (loop_en) begin
                addr_d  = '0;
                state_d = S_FETCH;
            end else begin
                state_d = S_END;
            end
        end
        // Abort overrides everything, including a simultaneous start.
        if (stop) begin
            state_d = S_IDLE;
            addr_d  = '0;
        end
    end

    // Sequencer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            dur_q   <= '0;
            dcnt_q  <= '0;
            tick_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            dur_q   <= dur_d;
            dcnt_q  <= dcnt_d;
            tick_q  <= tick_d;
        end
    end

    for (genvar k = 0; k < CH; k++) begin : g_ch
        tone_ch #(.HP_W(HP_W)) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .ld    (ld),
            .en    (run),
            .hp_in (rom_data[DUR_W+k*HP_W +: HP_W]),
            .bz    (buzzer[k])
        );
    end

    assign rom_addr = addr_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_END);
endmodule
